// File: rtl/mips_mem_pkg.sv
// Shared types and default geometry for the MIPS data-side RAM slice.
// Imported by the access controller and the storage array.
package mips_mem_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0000_1000;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 256;
  localparam int unsigned DEFAULT_LATENCY     = 2;

  // Wait counter holds at most LATENCY-1 (LATENCY <= 7).
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mips_ram_array.sv
// Word-organised storage: one synchronous byte-enabled write port and
// one asynchronous read port. Contents are never cleared.
module mips_ram_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned IDX_W       = $clog2(DEFAULT_DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wbe,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_data_ram.sv
// Data RAM with a fixed-latency waitrequest handshake for the MIPS core.
// Requests are latched in IDLE, timed out in WAIT and answered in ACK.
module mips_data_ram
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mem_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             latch;

  logic [IDX_W-1:0] lat_idx;
  logic [31:0]      lat_wdata;
  logic [3:0]       lat_be;
  logic             lat_read;
  logic             lat_write;
  logic             lat_err;

  logic             request;
  logic [32:0]      addr_ext;
  logic [32:0]      addr_lim;
  logic [31:0]      offset;
  logic             in_range;
  logic             dec_err;
  logic [IDX_W-1:0] dec_idx;

  logic             ram_we;
  logic [31:0]      ram_rdata;

  assign request = data_read | data_write;

  // Range check in 33 bits so a window ending at 2^32 cannot wrap.
  assign addr_ext = {1'b0, data_address};
  assign addr_lim = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  assign in_range = (addr_ext >= {1'b0, BASE_ADDR}) && (addr_ext < addr_lim);
  assign offset   = data_address - BASE_ADDR;
  assign dec_idx  = IDX_W'(offset >> 2);
  assign dec_err  = (data_address[1:0] != 2'b00) || !in_range ||
                    (data_read && data_write);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
    end else if (latch) begin
      lat_idx   <= dec_idx;
      lat_wdata <= writedata;
      lat_be    <= byteenable;
      lat_read  <= data_read;
      lat_write <= data_write;
      lat_err   <= dec_err;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          latch = 1'b1;
          if (LATENCY <= 1) begin
            state_n = ACK;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (!request) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_n = ACK;
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Reset in the ACK cycle suppresses both the commit and the response.
  assign ram_we = (state == ACK) && lat_write && !lat_err && !reset;

  mips_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .waddr(lat_idx),
    .wdata(lat_wdata),
    .wbe  (lat_be),
    .raddr(lat_idx),
    .rdata(ram_rdata)
  );

  assign waitrequest = request && (reset || (state != ACK));
  assign err         = (state == ACK) && lat_err && !reset;
  assign readdata    = ((state == ACK) && lat_read && !lat_err && !reset) ?
                       ram_rdata : '0;

endmodule

// File: tb/tb_mips_data_ram.sv
// Self-checking bench for mips_data_ram: LATENCY=2 and LATENCY=1 instances
// checked against a word-array reference model with byte-lane merging.
module tb_mips_data_ram;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rd0, wr0, wreq0, err0;
  logic [31:0] a0, wd0, rdd0;
  logic [3:0]  be0;
  logic        rd1, wr1, wreq1, err1;
  logic [31:0] a1, wd1, rdd1;
  logic [3:0]  be1;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [2][DEPTH];

  mips_data_ram #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .data_address(a0), .data_read(rd0),
    .data_write(wr0), .writedata(wd0), .byteenable(be0),
    .waitrequest(wreq0), .readdata(rdd0), .err(err0)
  );

  mips_data_ram #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .data_address(a1), .data_read(rd1),
    .data_write(wr1), .writedata(wd1), .byteenable(be1),
    .waitrequest(wreq1), .readdata(rdd1), .err(err1)
  );

  function automatic bit exp_err(input bit rd, input bit wr, input logic [31:0] a);
    return (a % 4 != 0) || (a < BASE) || (a >= BASE + 4 * DEPTH) || (rd && wr);
  endfunction

  function automatic void model_write(input int s, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] be);
    int unsigned w = (a - BASE) / 4;
    for (int b = 0; b < 4; b++)
      if (be[b]) model[s][w][8*b +: 8] = wd[8*b +: 8];
  endfunction

  task automatic drive(input int s, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (s == 0) begin rd0 = rd; wr0 = wr; a0 = a; wd0 = wd; be0 = be; end
    else        begin rd1 = rd; wr1 = wr; a1 = a; wd1 = wd; be1 = be; end
  endtask

  // Starts at a negedge, holds the request until waitrequest drops, then
  // releases it at the following negedge (the post-ACK IDLE cycle).
  task automatic access(input int s, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int ack_cyc, output logic [31:0] rdv,
                        output logic ev, output bit early);
    ack_cyc = -1; rdv = '0; ev = 1'b0; early = 1'b0;
    drive(s, rd, wr, a, wd, be);
    for (int c = 0; c < 20; c++) begin
      #1;
      if ((s == 0 ? wreq0 : wreq1) === 1'b0) begin
        ack_cyc = c;
        rdv = (s == 0) ? rdd0 : rdd1;
        ev  = (s == 0) ? err0 : err1;
        break;
      end
      if ((s == 0 ? err0 : err1) !== 1'b0 || (s == 0 ? rdd0 : rdd1) !== 32'h0) early = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    drive(s, 0, 0, '0, '0, '0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1, 0, 32'h1000, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    #1;
    checks++; if (wreq0 !== 1'b1) begin errors++; $display("FAIL reset_wreq_req got=%b exp=1", wreq0); end
    checks++; if (rdd0 !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdd0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err0); end
    checks++; if (wreq1 !== 1'b0) begin errors++; $display("FAIL reset_wreq_noreq got=%b exp=0", wreq1); end
    @(negedge clk);
    drive(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (wreq0 !== 1'b0 || err0 !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle wreq=%b err=%b exp 0 0", wreq0, err0); end
  endtask

  task automatic test_write_read();
    int c; logic [31:0] r; logic e; bit early;
    access(0, 0, 1, 32'h1004, 32'hDEADBEEF, 4'hF, c, r, e, early);
    checks++; if (c !== 2) begin errors++; $display("FAIL wr_latency got=%0d exp=2", c); end
    checks++; if (e !== 1'b0 || early) begin errors++; $display("FAIL wr_err got=%b early=%b exp 0", e, early); end
    model_write(0, 32'h1004, 32'hDEADBEEF, 4'hF);
    access(0, 1, 0, 32'h1004, '0, '0, c, r, e, early);
    checks++; if (c !== 2) begin errors++; $display("FAIL rd_latency got=%0d exp=2", c); end
    checks++; if (r !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++; $display("FAIL rd_data got=%h err=%b exp=deadbeef 0", r, e); end
  endtask

  task automatic test_byte_write();
    int c; logic [31:0] r; logic e; bit early;
    access(0, 0, 1, 32'h1004, 32'h0000_5500, 4'b0010, c, r, e, early);
    model_write(0, 32'h1004, 32'h0000_5500, 4'b0010);
    access(0, 1, 0, 32'h1004, '0, '0, c, r, e, early);
    checks++; if (r !== 32'hDEAD55EF) begin errors++; $display("FAIL byte_lane got=%h exp=dead55ef", r); end
    access(0, 0, 1, 32'h1004, 32'h1111_1111, 4'b0000, c, r, e, early);
    checks++; if (c !== 2 || e !== 1'b0) begin errors++; $display("FAIL be0_ack cyc=%0d err=%b exp 2 0", c, e); end
    access(0, 1, 0, 32'h1004, '0, '0, c, r, e, early);
    checks++; if (r !== 32'hDEAD55EF) begin errors++; $display("FAIL be0_nochange got=%h exp=dead55ef", r); end
  endtask

  task automatic test_errors();
    int c; logic [31:0] r; logic e; bit early;
    logic [31:0] bad [5];
    bad[0] = 32'h1002; bad[1] = 32'h2000; bad[2] = 32'h0FFC; bad[3] = 32'h1005; bad[4] = 32'hFFFF_FFFC;
    access(0, 0, 1, 32'h1008, 32'hA5A5_0001, 4'hF, c, r, e, early);
    model_write(0, 32'h1008, 32'hA5A5_0001, 4'hF);
    for (int i = 0; i < 5; i++) begin
      access(0, 1, 0, bad[i], '0, '0, c, r, e, early);
      checks++; if (e !== 1'b1 || r !== 32'h0 || c !== 2) begin
        errors++; $display("FAIL err_read[%0d] err=%b data=%h cyc=%0d exp 1 0 2", i, e, r, c); end
    end
    access(0, 0, 1, 32'h1005, 32'hFFFF_FFFF, 4'hF, c, r, e, early);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_miswrite got=%b exp=1", e); end
    access(0, 1, 1, 32'h1008, 32'h0BAD_0BAD, 4'hF, c, r, e, early);
    checks++; if (e !== 1'b1 || r !== 32'h0) begin
      errors++; $display("FAIL err_both err=%b data=%h exp 1 0", e, r); end
    access(0, 1, 0, 32'h1008, '0, '0, c, r, e, early);
    checks++; if (r !== model[0][2] || e !== 1'b0) begin
      errors++; $display("FAIL err_both_nochange got=%h exp=%h", r, model[0][2]); end
    access(0, 1, 0, 32'h1004, '0, '0, c, r, e, early);
    checks++; if (r !== model[0][1]) begin
      errors++; $display("FAIL err_miswrite_nochange got=%h exp=%h", r, model[0][1]); end
    access(0, 0, 1, 32'h13FC, 32'hCAFE_F00D, 4'hF, c, r, e, early);
    model_write(0, 32'h13FC, 32'hCAFE_F00D, 4'hF);
    access(0, 1, 0, 32'h13FC, '0, '0, c, r, e, early);
    checks++; if (r !== 32'hCAFE_F00D || e !== 1'b0) begin
      errors++; $display("FAIL last_word got=%h err=%b exp=cafef00d 0", r, e); end
  endtask

  task automatic test_abort();
    int c; logic [31:0] r; logic e; bit early;
    logic [31:0] prior = $urandom;
    access(0, 0, 1, 32'h1010, prior, 4'hF, c, r, e, early);
    model_write(0, 32'h1010, prior, 4'hF);
    // Request dropped in WAIT.
    drive(0, 0, 1, 32'h1010, 32'h12345678, 4'hF);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, '0);
    #1;
    checks++; if (wreq0 !== 1'b0 || err0 !== 1'b0) begin
      errors++; $display("FAIL abort_drop wreq=%b err=%b exp 0 0", wreq0, err0); end
    @(negedge clk); #1;
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL abort_noresp err=%b exp=0", err0); end
    access(0, 1, 0, 32'h1010, '0, '0, c, r, e, early);
    checks++; if (r !== prior) begin errors++; $display("FAIL abort_drop_nowrite got=%h exp=%h", r, prior); end
    // Reset in WAIT with request held.
    drive(0, 0, 1, 32'h1010, 32'h12345678, 4'hF);
    @(negedge clk);
    reset = 1'b1; #1;
    checks++; if (wreq0 !== 1'b1 || err0 !== 1'b0 || rdd0 !== 32'h0) begin
      errors++; $display("FAIL reset_wait wreq=%b err=%b data=%h exp 1 0 0", wreq0, err0, rdd0); end
    @(negedge clk);
    reset = 1'b0; drive(0, 0, 0, '0, '0, '0);
    access(0, 1, 0, 32'h1010, '0, '0, c, r, e, early);
    checks++; if (r !== prior) begin errors++; $display("FAIL reset_wait_nowrite got=%h exp=%h", r, prior); end
    // Reset in ACK with request held.
    drive(0, 0, 1, 32'h1010, 32'h12345678, 4'hF);
    @(negedge clk); @(negedge clk);
    reset = 1'b1; #1;
    checks++; if (wreq0 !== 1'b1 || err0 !== 1'b0) begin
      errors++; $display("FAIL reset_ack wreq=%b err=%b exp 1 0", wreq0, err0); end
    @(negedge clk);
    reset = 1'b0; drive(0, 0, 0, '0, '0, '0);
    access(0, 1, 0, 32'h1010, '0, '0, c, r, e, early);
    checks++; if (r !== prior) begin errors++; $display("FAIL reset_ack_nowrite got=%h exp=%h", r, prior); end
  endtask

  task automatic test_latch();
    int c; logic [31:0] r; logic e; bit early;
    logic [31:0] x = $urandom;
    logic [31:0] y = $urandom;
    access(0, 0, 1, 32'h1024, y, 4'hF, c, r, e, early);
    model_write(0, 32'h1024, y, 4'hF);
    drive(0, 0, 1, 32'h1020, x, 4'hF);
    @(negedge clk);
    drive(0, 0, 1, 32'h1024, ~x, 4'h3);
    @(negedge clk); #1;
    checks++; if (wreq0 !== 1'b0 || err0 !== 1'b0) begin
      errors++; $display("FAIL latch_ack wreq=%b err=%b exp 0 0", wreq0, err0); end
    @(negedge clk);
    drive(0, 0, 0, '0, '0, '0);
    model_write(0, 32'h1020, x, 4'hF);
    access(0, 1, 0, 32'h1020, '0, '0, c, r, e, early);
    checks++; if (r !== x) begin errors++; $display("FAIL latch_target got=%h exp=%h", r, x); end
    access(0, 1, 0, 32'h1024, '0, '0, c, r, e, early);
    checks++; if (r !== y) begin errors++; $display("FAIL latch_other got=%h exp=%h", r, y); end
  endtask

  task automatic test_random();
    int c; logic [31:0] r; logic e; bit early;
    int unsigned pool [8];
    for (int i = 0; i < 8; i++) begin
      pool[i] = (i == 0) ? 0 : (i == 7) ? DEPTH - 1 : $urandom_range(16, DEPTH - 2);
      access(0, 0, 1, BASE + 4 * pool[i], pool[i] * 32'h01010101 ^ 32'h5A5A0000, 4'hF, c, r, e, early);
      model_write(0, BASE + 4 * pool[i], pool[i] * 32'h01010101 ^ 32'h5A5A0000, 4'hF);
    end
    for (int n = 0; n < 40; n++) begin
      int unsigned k = $urandom_range(0, 9);
      int unsigned kind = $urandom_range(0, 4);
      logic [31:0] a = BASE + 4 * pool[$urandom_range(0, 7)];
      logic [31:0] wd = $urandom;
      logic [3:0] be = 4'($urandom);
      bit rd = (kind <= 1) || (kind == 4);
      bit wr = (kind >= 2);
      bit xe;
      logic [31:0] xr;
      if (k == 6) a = a + $urandom_range(1, 3);
      else if (k == 7) a = BASE - 4 * $urandom_range(1, 4);
      else if (k == 8) a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
      xe = exp_err(rd, wr, a);
      xr = (!xe && rd && !wr) ? model[0][(a - BASE) / 4] : 32'h0;
      access(0, rd, wr, a, wd, be, c, r, e, early);
      checks++; if (c !== 2) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=2", n, c); end
      checks++; if (e !== xe) begin errors++; $display("FAIL rnd%0d_err a=%h got=%b exp=%b", n, a, e, xe); end
      checks++; if (r !== xr) begin errors++; $display("FAIL rnd%0d_data a=%h got=%h exp=%h", n, a, r, xr); end
      checks++; if (early) begin errors++; $display("FAIL rnd%0d_early_resp got=1 exp=0", n); end
      if (!xe && wr) model_write(0, a, wd, be);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v = $urandom;
    bit exp_w [6];
    bit exp_w1 [5];
    exp_w  = '{1, 1, 0, 1, 1, 0};
    exp_w1 = '{1, 0, 1, 0, 1};
    // LATENCY=1: write then read of the same word, back to back.
    drive(1, 0, 1, 32'h1040, v, 4'hF); #1;
    checks++; if (wreq1 !== 1'b1) begin errors++; $display("FAIL l1_wr_c0 wreq=%b exp=1", wreq1); end
    @(negedge clk); #1;
    checks++; if (wreq1 !== 1'b0 || err1 !== 1'b0) begin
      errors++; $display("FAIL l1_wr_ack wreq=%b err=%b exp 0 0", wreq1, err1); end
    model_write(1, 32'h1040, v, 4'hF);
    @(negedge clk);
    drive(1, 1, 0, 32'h1040, '0, '0); #1;
    checks++; if (wreq1 !== 1'b1) begin errors++; $display("FAIL l1_turnaround wreq=%b exp=1", wreq1); end
    @(negedge clk); #1;
    checks++; if (wreq1 !== 1'b0 || rdd1 !== v) begin
      errors++; $display("FAIL l1_raw wreq=%b data=%h exp 0 %h", wreq1, rdd1, v); end
    @(negedge clk);
    drive(1, 0, 0, '0, '0, '0);
    @(negedge clk);
    // LATENCY=1: held reads ack in cycles 1 and 3.
    drive(1, 1, 0, 32'h1040, '0, '0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (wreq1 !== exp_w1[c] || rdd1 !== (exp_w1[c] ? 32'h0 : model[1][16])) begin
        errors++; $display("FAIL l1_b2b_c%0d wreq=%b data=%h exp %b %h", c, wreq1, rdd1,
                           exp_w1[c], exp_w1[c] ? 32'h0 : model[1][16]); end
      @(negedge clk);
    end
    drive(1, 0, 0, '0, '0, '0);
    @(negedge clk);
    // LATENCY=2: held reads ack in cycles 2 and 5.
    drive(0, 1, 0, 32'h1004, '0, '0);
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (wreq0 !== exp_w[c] || rdd0 !== (exp_w[c] ? 32'h0 : model[0][1])) begin
        errors++; $display("FAIL l2_b2b_c%0d wreq=%b data=%h exp %b %h", c, wreq0, rdd0,
                           exp_w[c], exp_w[c] ? 32'h0 : model[0][1]); end
      @(negedge clk);
    end
    drive(0, 0, 0, '0, '0, '0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    test_reset();
    test_write_read();
    test_byte_write();
    test_errors();
    test_abort();
    test_latch();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_data_ram.md
MIPS_DATA_RAM -- requirements
Module: mips_data_ram

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000; byte address of word 0.
REQ-002 Parameter DEPTH_WORDS, default 256; number of 32-bit words, power of two.
REQ-003 Parameter LATENCY, default 2; wait cycles per access, legal range 1..7.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 data_address  in  32  CPU byte address.
REQ-007 data_read  in  1  read request, held by CPU until waitrequest low.
REQ-008 data_write  in  1  write request, held by CPU until waitrequest low.
REQ-009 writedata  in  32  write data (CPU data_out).
REQ-010 byteenable  in  4  write lane enables; bit i covers bits 8i+7:8i.
REQ-011 waitrequest  out  1  high = transaction not complete, CPU must hold.
REQ-012 readdata  out  32  read data, valid only in read ACK cycle.
REQ-013 err  out  1  error response, valid only in ACK cycle.

Function
REQ-014 FSM states IDLE, WAIT, ACK.
REQ-015 Request = data_read OR data_write.
REQ-016 IDLE with request: latch address, writedata, byteenable, read/write kind; next WAIT with cnt=LATENCY-1, or ACK directly if LATENCY=1.
REQ-017 WAIT: cnt decrements each cycle; cnt=1 -> ACK.
REQ-018 ACK: next state IDLE unconditionally.
REQ-019 waitrequest = request AND state!=ACK (combinational); a request first seen in cycle 0 completes in cycle LATENCY.
REQ-020 Back-to-back: one IDLE turnaround cycle after every ACK; waitrequest stays high during it if request held.
REQ-021 Latched values are used for the access; input changes during WAIT are ignored.
REQ-022 Request deasserted in WAIT: abort, next IDLE, no write, no response.
REQ-023 Write commits at the rising edge ending the ACK cycle, only enabled lanes updated; byteenable=4'b0000 acks with no change.
REQ-024 readdata = stored word in read ACK cycle, else 32'h0.
REQ-025 Error when data_address[1:0]!=0, or address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS), or data_read AND data_write both high at latch.
REQ-026 Error access: err=1 in ACK, readdata=0, no write; err=0 in all other cycles.
REQ-027 Word index = (address-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits after range check.
REQ-028 Read-after-write to same word in consecutive transactions returns new data.

Reset
REQ-029 reset forces IDLE, cnt=0; waitrequest=request, readdata=0, err=0 in the reset cycle.
REQ-030 Reset mid-WAIT or in ACK aborts: pending write not committed.
REQ-031 Memory contents not cleared by reset; undefined until written.
REQ-032 Reset has priority over every other event in the same cycle.

Structure
REQ-033 Package mips_mem_pkg holds the state enum, default BASE_ADDR/DEPTH_WORDS/LATENCY constants.
REQ-034 Storage in sub-module mips_ram_array (1 sync write port with byte enables, 1 async read port); FSM, counter and decode in mips_data_ram.

Verification
REQ-035 LATENCY=2: write 32'hDEADBEEF, be=4'hF, addr 32'h0000_1004 -> waitrequest high 2 cycles, low cycle 2, err=0; later read same addr -> readdata 32'hDEADBEEF in ACK.
REQ-036 Byte write be=4'b0010, data 32'h0000_5500 over 32'hDEADBEEF -> read returns 32'hDEAD55EF.
REQ-037 Read addr 32'h0000_1002 and addr 32'h0000_2000 -> err=1 in ACK, readdata 0, memory unchanged.
REQ-038 data_read and data_write both high at 32'h0000_1008 -> err=1, word unchanged.
REQ-039 Write 32'h12345678 to 32'h0000_1010, deassert data_write in WAIT or assert reset in WAIT -> no response, later read returns prior value.
REQ-040 LATENCY=1, two back-to-back reads held -> ACK cycles 1 and 3, IDLE turnaround with waitrequest high in cycle 2.
